fbconfig_avmm_responder: RTL and testbench

FBCONFIG_AVMM_RESPONDER -- requirements
Module: fbconfig_avmm_responder

---
 rtl/fbconfig_avmm_pkg.sv | 20 ++
 rtl/fbconfig_lat_pipe.sv | 34 +++
 rtl/fbconfig_avmm_responder.sv | 146 ++++++++++++++
 tb/tb_fbconfig_avmm_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fbconfig_avmm_pkg.sv
// Shared constants, host-port FSM states and address decode for the
// framebuffer-config AVMM responder.
package fbconfig_avmm_pkg;

    localparam int WORD_W = 64;
    localparam int LANES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_RDWAIT = 2'd2
    } host_st_e;

    // Byte address to word index; callers check address >= base separately.
    function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                  input logic [63:0] base);
        return (addr - base) >> 3;
    endfunction

endpackage

// File: rtl/fbconfig_lat_pipe.sv
// Fixed-length data/valid delay line with synchronous active-low flush.
module fbconfig_lat_pipe #(
    parameter int DATA_W = 64,
    parameter int LAT    = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LAT-1:0]    valid_q;
    logic [DATA_W-1:0] data_q [LAT];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/fbconfig_avmm_responder.sv
// 64-bit word store with a priority AVMM slave port and a req/ack host port.
// Optional error counter enabled by defining FBCFG_RESP_ERRCNT_EN.
//
// state     | meaning
// ST_IDLE   | no host access pending
// ST_GRANT  | host request held, waiting for an idle avmm cycle to ack
// ST_RDWAIT | host read accepted, waiting out the read latency
module fbconfig_avmm_responder #(
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        resetn,
`ifdef FBCFG_RESP_ERRCNT_EN
    output logic [15:0] err_count,
`endif
    input  logic [63:0] avmm_address,
    input  logic [7:0]  avmm_byteenable,
    input  logic        avmm_read,
    output logic [63:0] avmm_readdata,
    input  logic        avmm_write,
    input  logic [63:0] avmm_writedata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_index,
    input  logic [63:0] host_wdata,
    output logic        host_ack,
    output logic [63:0] host_rdata,
    output logic        host_rvalid
);
    import fbconfig_avmm_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    logic [63:0]       av_idx;
    logic [IDX_W-1:0]  av_widx, hs_widx;
    logic              av_in_range, av_busy, av_wr_ok, av_rd_ok;
    logic              hs_in_range, hs_wr_ok, hs_rd_go, grant_go;
    logic [WORD_W-1:0] av_rdata, hs_rdata;
    logic              av_pipe_vld, hs_pipe_vld;
    logic [WORD_W-1:0] av_pipe_data, hs_pipe_data, av_hold_q;

    host_st_e st_q, st_d;
    logic [1:0] wait_q, wait_d;

    assign av_idx      = addr_to_index(avmm_address, BASE_ADDR);
    assign av_widx     = av_idx[IDX_W-1:0];
    assign av_in_range = (avmm_address >= BASE_ADDR) && (av_idx < 64'(DEPTH_WORDS));
    assign av_busy     = avmm_read | avmm_write;
    assign av_wr_ok    = resetn & avmm_write & av_in_range;
    // A read colliding with a write yields a zero slot rather than the old word.
    assign av_rd_ok    = avmm_read & ~avmm_write & av_in_range;

    assign hs_widx     = host_index[IDX_W-1:0];
    assign hs_in_range = {16'b0, host_index} < 32'(DEPTH_WORDS);
    assign hs_wr_ok    = resetn & grant_go & host_we & hs_in_range;
    assign hs_rd_go    = grant_go & ~host_we;

    always_comb begin
        st_d     = st_q;
        wait_d   = wait_q;
        grant_go = 1'b0;
        case (st_q)
            ST_IDLE:   if (host_req) st_d = ST_GRANT;
            ST_GRANT:
                if (!av_busy) begin
                    grant_go = 1'b1;
                    if (!host_we && READ_LATENCY > 1) begin
                        st_d   = ST_RDWAIT;
                        wait_d = 2'(READ_LATENCY - 2);
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            ST_RDWAIT:
                if (wait_q == 2'd0) st_d = ST_IDLE;
                else                wait_d = wait_q - 2'd1;
            default:   st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            st_q      <= ST_IDLE;
            wait_q    <= 2'd0;
            av_hold_q <= '0;
        end else begin
            st_q      <= st_d;
            wait_q    <= wait_d;
            av_hold_q <= avmm_readdata;
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < LANES; b++) begin
            if (av_wr_ok && avmm_byteenable[b])
                mem[av_widx][8*b +: 8] <= avmm_writedata[8*b +: 8];
            else if (hs_wr_ok)
                mem[hs_widx][8*b +: 8] <= host_wdata[8*b +: 8];
        end
    end

    assign av_rdata = av_rd_ok    ? mem[av_widx] : '0;
    assign hs_rdata = hs_in_range ? mem[hs_widx] : '0;

    fbconfig_lat_pipe #(.DATA_W(WORD_W), .LAT(READ_LATENCY)) u_av_pipe (
        .clock   (clock),
        .resetn  (resetn),
        .valid_i (avmm_read),
        .data_i  (av_rdata),
        .valid_o (av_pipe_vld),
        .data_o  (av_pipe_data)
    );

    fbconfig_lat_pipe #(.DATA_W(WORD_W), .LAT(READ_LATENCY)) u_hs_pipe (
        .clock   (clock),
        .resetn  (resetn),
        .valid_i (hs_rd_go),
        .data_i  (hs_rdata),
        .valid_o (hs_pipe_vld),
        .data_o  (hs_pipe_data)
    );

    assign avmm_readdata = !resetn    ? '0 : (av_pipe_vld ? av_pipe_data : av_hold_q);
    assign host_ack      = resetn & grant_go;
    assign host_rvalid   = resetn & hs_pipe_vld;
    assign host_rdata    = host_rvalid ? hs_pipe_data : '0;

`ifdef FBCFG_RESP_ERRCNT_EN
    logic [15:0] err_q;
    logic        err_evt;

    assign err_evt = (av_busy & ~av_in_range) | (avmm_read & avmm_write);

    always_ff @(posedge clock) begin
        if (!resetn)                          err_q <= 16'h0;
        else if (err_evt && err_q != 16'hFFFF) err_q <= err_q + 16'h1;
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_fbconfig_avmm_responder.sv
// Directed bench for fbconfig_avmm_responder (BASE 0x1000, 16 words, latency 3).
module tb_fbconfig_avmm_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_0000_1000;
    localparam int          DEPTH = 16;
    localparam int          LAT   = 3;
    localparam logic [63:0] W5    = 64'h0BAD_F00D_1234_5678;

    logic        clock, resetn;
    logic [63:0] avmm_address, avmm_readdata, avmm_writedata;
    logic [7:0]  avmm_byteenable;
    logic        avmm_read, avmm_write;
    logic        host_req, host_we, host_ack, host_rvalid;
    logic [15:0] host_index;
    logic [63:0] host_wdata, host_rdata;
`ifdef FBCFG_RESP_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fbconfig_avmm_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
`ifdef FBCFG_RESP_ERRCNT_EN
        .err_count       (err_count),
`endif
        .avmm_address    (avmm_address),
        .avmm_byteenable (avmm_byteenable),
        .avmm_read       (avmm_read),
        .avmm_readdata   (avmm_readdata),
        .avmm_write      (avmm_write),
        .avmm_writedata  (avmm_writedata),
        .host_req        (host_req),
        .host_we         (host_we),
        .host_index      (host_index),
        .host_wdata      (host_wdata),
        .host_ack        (host_ack),
        .host_rdata      (host_rdata),
        .host_rvalid     (host_rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        avmm_address = a; avmm_writedata = d; avmm_byteenable = be; avmm_write = 1'b1;
        tick();
        avmm_write = 1'b0;
    endtask

    // Issue one read; readdata must still show prev one edge early, exp at LAT edges.
    task automatic rd(input string tag, input logic [63:0] a,
                      input logic [63:0] exp, input logic [63:0] prev);
        avmm_address = a; avmm_read = 1'b1;
        tick();
        avmm_read = 1'b0;
        repeat (LAT - 2) tick();
        chk({tag, "_early"}, avmm_readdata, prev);
        tick();
        chk(tag, avmm_readdata, exp);
    endtask

    initial begin
        resetn = 1'b0; avmm_address = '0; avmm_byteenable = '0; avmm_read = 1'b0;
        avmm_write = 1'b0; avmm_writedata = '0; host_req = 1'b0; host_we = 1'b0;
        host_index = '0; host_wdata = '0;
        tick(); tick();
        chk("rst_readdata", avmm_readdata, 64'h0);
        chk("rst_ack", 64'(host_ack), 64'h0);
        chk("rst_rvalid", 64'(host_rvalid), 64'h0);
        chk("rst_rdata", host_rdata, 64'h0);
`ifdef FBCFG_RESP_ERRCNT_EN
        chk("rst_err", 64'(err_count), 64'h0);
`endif
        resetn = 1'b1;
        tick();

        wr(BASE + 8, 64'h1122334455667788, 8'hFF);
        rd("rd_full", BASE + 8, 64'h1122334455667788, 64'h0);
        wr(BASE + 8, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd("rd_partial", BASE + 8, 64'h11223344AAAAAAAA, 64'h1122334455667788);

        rd("rd_oor_top", BASE + 8 * DEPTH, 64'h0, 64'h11223344AAAAAAAA);
`ifdef FBCFG_RESP_ERRCNT_EN
        chk("err_oor_top", 64'(err_count), 64'd1);
`endif
        rd("rd_oor_low", BASE - 8, 64'h0, 64'h0);
`ifdef FBCFG_RESP_ERRCNT_EN
        chk("err_oor_low", 64'(err_count), 64'd2);
`endif
        wr(BASE + 3, 64'h0000_0000_0000_CAFE, 8'hFF);
        wr(BASE + 8 * DEPTH, 64'h0000_0000_0000_DEAD, 8'hFF);
        rd("rd_no_alias", BASE, 64'h0000_0000_0000_CAFE, 64'h0);
`ifdef FBCFG_RESP_ERRCNT_EN
        chk("err_oor_wr", 64'(err_count), 64'd3);
`endif

        avmm_address = BASE + 16; avmm_writedata = 64'h5; avmm_byteenable = 8'hFF;
        avmm_read = 1'b1; avmm_write = 1'b1;
        tick();
        avmm_read = 1'b0; avmm_write = 1'b0;
        repeat (LAT - 2) tick();
        chk("collide_early", avmm_readdata, 64'h0000_0000_0000_CAFE);
        tick();
        chk("collide_slot", avmm_readdata, 64'h0);
`ifdef FBCFG_RESP_ERRCNT_EN
        chk("err_collide", 64'(err_count), 64'd4);
`endif
        rd("rd_collide_wr", BASE + 16, 64'h5, 64'h0);

        host_req = 1'b1; host_we = 1'b1; host_index = 16'd5; host_wdata = W5;
        avmm_read = 1'b1; avmm_address = BASE + 16;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("host_ack_blocked", 64'(host_ack), 64'h0);
            tick();
        end
        avmm_read = 1'b0;
        #1;
        chk("host_wr_ack", 64'(host_ack), 64'h1);
        chk("rd_during_host", avmm_readdata, 64'h5);
        tick();
        host_req = 1'b0;
        #1;
        chk("host_ack_pulse", 64'(host_ack), 64'h0);
        rd("rd_host_written", BASE + 40, W5, 64'h5);

        host_req = 1'b1; host_we = 1'b0; host_index = 16'd5;
        #1;
        chk("host_rd_idle", 64'(host_ack), 64'h0);
        tick();
        chk("host_rd_ack", 64'(host_ack), 64'h1);
        tick();
        host_req = 1'b0;
        chk("host_rv_lat1", 64'(host_rvalid), 64'h0);
        tick();
        chk("host_rv_lat2", 64'(host_rvalid), 64'h0);
        tick();
        chk("host_rvalid", 64'(host_rvalid), 64'h1);
        chk("host_rdata", host_rdata, W5);
        tick();
        chk("host_rv_pulse", 64'(host_rvalid), 64'h0);

        host_req = 1'b1; host_we = 1'b0; host_index = 16'd20;
        tick();
        chk("host_oor_ack", 64'(host_ack), 64'h1);
        tick();
        host_req = 1'b0;
        tick(); tick();
        chk("host_oor_rvalid", 64'(host_rvalid), 64'h1);
        chk("host_oor_rdata", host_rdata, 64'h0);
        tick();

        avmm_address = BASE + 40; avmm_read = 1'b1;
        tick();
        avmm_read = 1'b0; resetn = 1'b0;
        #1;
        chk("rst_mid_low", avmm_readdata, 64'h0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            chk("rst_mid_flush", avmm_readdata, 64'h0);
            tick();
        end
`ifdef FBCFG_RESP_ERRCNT_EN
        chk("rst_mid_err", 64'(err_count), 64'h0);
`endif
        rd("rd_mem_kept", BASE + 40, W5, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
